bus_sram_responder: RTL and testbench
=====================================

Name: bus_sram_responder

Overview:
- Bus-slave end of the shared burst bus that DMA custom-instruction masters drive: answers beginTransaction requests with burst reads and burst writes into an internal word-wide SRAM.
- Sits on the bus next to the arbiter. Serves as the scratch/shared memory target for DMA transfers and as a protocol-accurate responder for master verification.
- Optional busy insertion on write beats exercises the masters' stall handling.

Parameters:
BASE_ADDR, 32'h5000_0000, byte base address of the responder window; must be aligned to the window size.
ADDR_WORDS_LOG2, 10, log2 of the SRAM depth in 32-bit words; window size is 4*2^ADDR_WORDS_LOG2 bytes.
READ_LATENCY, 2, idle cycles between the begin cycle and the first read data beat; range 1..15.
BUSY_PERIOD, 0, when nonzero, busyOut is asserted for 1 cycle after every BUSY_PERIOD accepted write beats; 0 disables busy insertion.

Ports:
clock  in  1  system clock, all logic on the rising edge
reset  in  1  asynchronous, active-low
beginTransactionIn  in  1  1-cycle start pulse from the granted master
addressDataIn  in  32  byte address in the begin cycle; write data in data beats
burstSizeIn  in  8  beats minus 1, sampled in the begin cycle
readNotWriteIn  in  1  1 = read, sampled in the begin cycle
byteEnablesIn  in  4  byte lanes, sampled in the begin cycle, applied to every write beat
dataValidIn  in  1  write beat valid
endTransactionIn  in  1  master end-of-write pulse
addressDataOut  out  32  read data; 0 when not driving
dataValidOut  out  1  read beat valid
endTransactionOut  out  1  1-cycle end pulse for a read or error-terminated read
busyOut  out  1  write stall; a beat presented while busyOut=1 is not accepted
busErrorOut  out  1  1-cycle error pulse

Behaviour:
- Reset: all outputs 0, state IDLE. SRAM contents are not reset. Reset asserted mid-transaction returns the block to IDLE immediately, with all outputs 0 asynchronously.
- Hit: in IDLE, beginTransactionIn=1 and addressDataIn[31:ADDR_WORDS_LOG2+2] equals BASE_ADDR's upper bits. Latch word index = addressDataIn[ADDR_WORDS_LOG2+1:2], len = burstSizeIn+1 (9 bits, 1..256), readNotWrite, byte enables. A miss is ignored; the block stays IDLE.
- Error condition: addressDataIn[1:0]!=0, OR index+len > 2^ADDR_WORDS_LOG2. The check is combinational in the begin cycle.
- beginTransactionIn outside IDLE is ignored.
- States: IDLE, RD_WAIT, RD_BURST, RD_END, WR, ERR_RD, ERR_WR.
- Read path:
  - IDLE -> RD_WAIT; a counter counts READ_LATENCY-1 cycles, then -> RD_BURST.
  - RD_BURST: dataValidOut=1, addressDataOut=mem[idx] for len consecutive cycles; idx increments each cycle.
  - The first beat appears exactly READ_LATENCY+1 cycles after the begin cycle (begin at cycle 0, first beat at cycle READ_LATENCY+1).
  - The SRAM read is synchronous: the address is presented one cycle ahead.
  - RD_END: endTransactionOut=1 for 1 cycle, then IDLE.
- Write path:
  - IDLE -> WR.
  - A beat is accepted when dataValidIn=1 and busyOut=0: mem[idx] is written per byte enable and idx increments.
  - Beats beyond len are discarded.
  - endTransactionIn=1 -> IDLE; a beat on the same cycle is still accepted.
  - busyOut is a register: after the BUSY_PERIOD-th accepted beat (counter reaches BUSY_PERIOD), busyOut=1 for the next cycle, then the counter clears.
- Error path:
  - ERR_RD: busErrorOut=1 and endTransactionOut=1 in the same cycle, 1 cycle after begin, then IDLE.
  - ERR_WR: busErrorOut=1 for 1 cycle after begin; data is discarded until endTransactionIn, then IDLE.
- Write then read of the same word in back-to-back transactions returns the new data, because the read is at least 2 cycles later.

Decomposition:
- Package bus_resp_pkg:
  - state enum
  - burst length width (9)
  - function computing window hit and bounds error
- One sub-module, bus_resp_sram: single-port, byte-enable write, synchronous read, 2^ADDR_WORDS_LOG2 x 32. Inferable as block RAM.

Test Plan:
- Reset hold, then release -> all outputs 0. Assert reset during RD_BURST -> dataValidOut drops immediately, next begin served normally.
- Write burst at BASE_ADDR+0x10, burstSizeIn=2, data 10/20/30, byteEnablesIn=4'hF, BUSY_PERIOD=2 -> busyOut=1 exactly one cycle after the 2nd accepted beat. Third word held by the master during busy is accepted afterwards.
- Read back the same address, burstSizeIn=2, READ_LATENCY=2 -> dataValidOut high on cycles 3,4,5 after begin with 10,20,30; endTransactionOut on cycle 6.
- Write 32'hAABBCCDD with byteEnablesIn=4'b0101 over 0x11223344 -> readback 32'h11BB33DD.
- Begin at BASE_ADDR+0x2 (misaligned) read -> busErrorOut and endTransactionOut together, 1 cycle after begin, no dataValidOut.
- Begin at last word with burstSizeIn=1 (write) -> busErrorOut pulse, memory unchanged. Begin at an address outside the window -> no response on any output.

Source files
------------

// File: rtl/bus_resp_pkg.sv
// Shared types and begin-cycle decode for the bus SRAM responder.
package bus_resp_pkg;

  // Burst length 1..256 needs 9 bits.
  localparam int LEN_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    RD_END,
    WR,
    ERR_RD,
    ERR_WR
  } state_t;

  typedef struct packed {
    logic hit;
    logic err;
  } begin_chk_t;

  // Window hit on the upper address bits; error when misaligned or the burst runs off the end.
  function automatic begin_chk_t decode_begin(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int unsigned awl,
                                              input logic [LEN_W-1:0] len);
    begin_chk_t  r;
    logic [32:0] idx;
    logic [32:0] depth;
    depth = 33'd1 << awl;
    idx   = {1'b0, addr >> 2} & (depth - 33'd1);
    r.hit = ((addr ^ base) >> (awl + 2)) == 32'd0;
    r.err = (addr[1:0] != 2'b00) || ((idx + {24'd0, len}) > depth);
    return r;
  endfunction

endpackage

// File: rtl/bus_sram_responder_if.sv
// Burst bus signals between a granted master and the SRAM responder.
interface bus_sram_responder_if;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic [3:0]  byteEnablesIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busyOut;
  logic        busErrorOut;

  modport slave (
    input  beginTransactionIn, addressDataIn, burstSizeIn, readNotWriteIn,
           byteEnablesIn, dataValidIn, endTransactionIn,
    output addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
  );

  modport master (
    output beginTransactionIn, addressDataIn, burstSizeIn, readNotWriteIn,
           byteEnablesIn, dataValidIn, endTransactionIn,
    input  addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
  );
endinterface

// File: rtl/bus_resp_sram.sv
// Single-port word SRAM with byte-enable write and registered read.
module bus_resp_sram #(
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  // Byte-lane write and synchronous read on the same address.
  // NOTE: no reset here -- a reset on the array or its read register would block RAM inference.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_sram_responder.sv
// Burst-bus slave serving reads and writes from an internal SRAM window.
import bus_resp_pkg::*;

module bus_sram_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h5000_0000,
  parameter int          ADDR_WORDS_LOG2 = 10,
  parameter int          READ_LATENCY    = 2,
  parameter int          BUSY_PERIOD     = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  bus_sram_responder_if.slave  bus
);

  localparam int          AW        = ADDR_WORDS_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(READ_LATENCY - 1);
  localparam logic [15:0] BUSY_P    = 16'(BUSY_PERIOD);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [3:0]       wait_q, wait_d;
  logic [3:0]       be_q, be_d;
  logic [15:0]      bcnt_q, bcnt_d;
  logic             busy_q, busy_d;
  logic             bus_err_q, bus_err_d;

  logic             sram_re, sram_we;
  logic [31:0]      sram_rdata;
  logic [LEN_W-1:0] len;
  begin_chk_t       chk;

  assign len = {1'b0, bus.burstSizeIn} + 9'd1;
  assign chk = decode_begin(bus.addressDataIn, BASE_ADDR, AW, len);

  // State and control registers; reset returns the block to IDLE at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      wait_q    <= '0;
      be_q      <= '0;
      bcnt_q    <= '0;
      busy_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      be_q      <= be_d;
      bcnt_q    <= bcnt_d;
      busy_q    <= busy_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state, burst bookkeeping and SRAM strobes.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    wait_d    = wait_q;
    be_d      = be_q;
    bcnt_d    = bcnt_q;
    busy_d    = 1'b0;
    bus_err_d = 1'b0;
    sram_re   = 1'b0;
    sram_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.beginTransactionIn && chk.hit) begin
          idx_d  = bus.addressDataIn[AW+1:2];
          rem_d  = len;
          be_d   = bus.byteEnablesIn;
          wait_d = WAIT_INIT;
          bcnt_d = '0;
          if (chk.err) begin
            bus_err_d = 1'b1;
            state_d   = bus.readNotWriteIn ? ERR_RD : ERR_WR;
          end else begin
            state_d   = bus.readNotWriteIn ? RD_WAIT : WR;
          end
        end
      end
      RD_WAIT: begin
        // Issue the first read one cycle before the first beat.
        if (wait_q == 4'd0) begin
          sram_re = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = RD_BURST;
        end else begin
          wait_d  = wait_q - 4'd1;
        end
      end
      RD_BURST: begin
        rem_d = rem_q - 9'd1;
        if (rem_q == 9'd1) begin
          state_d = RD_END;
        end else begin
          sram_re = 1'b1;
          idx_d   = idx_q + 1'b1;
        end
      end
      RD_END:  state_d = IDLE;
      ERR_RD:  state_d = IDLE;
      WR: begin
        if (bus.dataValidIn && !busy_q && rem_q != '0) begin
          sram_we = 1'b1;
          idx_d   = idx_q + 1'b1;
          rem_d   = rem_q - 9'd1;
          if (BUSY_P != 16'd0) begin
            if (bcnt_q + 16'd1 == BUSY_P) begin
              bcnt_d = '0;
              busy_d = !bus.endTransactionIn;
            end else begin
              bcnt_d = bcnt_q + 16'd1;
            end
          end
        end
        if (bus.endTransactionIn) state_d = IDLE;
      end
      ERR_WR: begin
        if (bus.endTransactionIn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  bus_resp_sram #(.AW(AW)) u_sram (
    .clock (clock),
    .en    (sram_re | sram_we),
    .we    (sram_we),
    .be    (be_q),
    .addr  (idx_q),
    .wdata (bus.addressDataIn),
    .rdata (sram_rdata)
  );

  assign bus.dataValidOut      = (state_q == RD_BURST);
  assign bus.addressDataOut    = (state_q == RD_BURST) ? sram_rdata : 32'd0;
  assign bus.endTransactionOut = (state_q == RD_END) || (state_q == ERR_RD);
  assign bus.busyOut           = busy_q;
  assign bus.busErrorOut       = bus_err_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed bench for bus_sram_responder with READ_LATENCY=2, BUSY_PERIOD=2.
module tb_bus_sram_responder;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  bus_sram_responder_if bus ();

  bus_sram_responder #(
    .BASE_ADDR       (BASE),
    .ADDR_WORDS_LOG2 (10),
    .READ_LATENCY    (2),
    .BUSY_PERIOD     (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.beginTransactionIn = 1'b0;
    bus.addressDataIn      = 32'd0;
    bus.burstSizeIn        = 8'd0;
    bus.readNotWriteIn     = 1'b0;
    bus.byteEnablesIn      = 4'h0;
    bus.dataValidIn        = 1'b0;
    bus.endTransactionIn   = 1'b0;
  endtask

  task automatic start(input logic [31:0] addr, input logic [7:0] bs,
                       input logic rnw, input logic [3:0] be);
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = addr;
    bus.burstSizeIn        = bs;
    bus.readNotWriteIn     = rnw;
    bus.byteEnablesIn      = be;
  endtask

  // Single-beat write ending in the data cycle.
  task automatic do_write1(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    start(addr, 8'd0, 1'b0, be);
    tick();
    idle_inputs();
    bus.addressDataIn    = data;
    bus.dataValidIn      = 1'b1;
    bus.endTransactionIn = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  // Single-beat read with a bounded wait for the data beat.
  task automatic do_read1(input logic [31:0] addr, output logic [31:0] data, output logic ok);
    ok   = 1'b0;
    data = 32'd0;
    start(addr, 8'd0, 1'b1, 4'hF);
    tick();
    idle_inputs();
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.dataValidOut) begin
        data = bus.addressDataOut;
        ok   = 1'b1;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.addressDataOut, bus.dataValidOut, bus.endTransactionOut, bus.busyOut, bus.busErrorOut} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {bus.addressDataOut, bus.dataValidOut, bus.endTransactionOut, bus.busyOut, bus.busErrorOut});
    end
  endtask

  task automatic test_write_busy();
    start(BASE + 32'h10, 8'd2, 1'b0, 4'hF);
    tick();
    idle_inputs();
    bus.dataValidIn = 1'b1; bus.addressDataIn = 32'd10;
    checks++;
    if (bus.busyOut !== 1'b0) begin failures++; $display("FAIL busy_c1 got=%b exp=0", bus.busyOut); end
    tick();
    bus.addressDataIn = 32'd20;
    checks++;
    if (bus.busyOut !== 1'b0) begin failures++; $display("FAIL busy_c2 got=%b exp=0", bus.busyOut); end
    tick();
    bus.addressDataIn = 32'd30;
    checks++;
    if (bus.busyOut !== 1'b1) begin failures++; $display("FAIL busy_c3 got=%b exp=1", bus.busyOut); end
    tick();
    bus.endTransactionIn = 1'b1;
    checks++;
    if (bus.busyOut !== 1'b0) begin failures++; $display("FAIL busy_c4 got=%b exp=0", bus.busyOut); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_read_burst();
    logic [31:0] words [3];
    logic        exp_dv, exp_end;
    logic [31:0] exp_d;
    words[0] = 32'd10; words[1] = 32'd20; words[2] = 32'd30;
    start(BASE + 32'h10, 8'd2, 1'b1, 4'hF);
    tick();
    idle_inputs();
    for (int c = 1; c <= 7; c++) begin
      exp_dv  = (c >= 3) && (c <= 5);
      exp_d   = exp_dv ? words[c-3] : 32'd0;
      exp_end = (c == 6);
      checks++;
      if (bus.dataValidOut !== exp_dv) begin
        failures++; $display("FAIL rd_valid c%0d got=%b exp=%b", c, bus.dataValidOut, exp_dv);
      end
      checks++;
      if (bus.addressDataOut !== exp_d) begin
        failures++; $display("FAIL rd_data c%0d got=%h exp=%h", c, bus.addressDataOut, exp_d);
      end
      checks++;
      if (bus.endTransactionOut !== exp_end) begin
        failures++; $display("FAIL rd_end c%0d got=%b exp=%b", c, bus.endTransactionOut, exp_end);
      end
      tick();
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    logic        ok;
    do_write1(BASE + 32'h20, 4'hF, 32'h1122_3344);
    do_write1(BASE + 32'h20, 4'b0101, 32'hAABB_CCDD);
    do_read1(BASE + 32'h20, d, ok);
    checks++;
    if (!ok || d !== 32'h11BB_33DD) begin
      failures++; $display("FAIL byte_enable ok=%b got=%h exp=11bb33dd", ok, d);
    end
  endtask

  task automatic test_misaligned_read();
    start(BASE + 32'h2, 8'd0, 1'b1, 4'hF);
    tick();
    idle_inputs();
    checks++;
    if ({bus.busErrorOut, bus.endTransactionOut, bus.dataValidOut} !== 3'b110) begin
      failures++; $display("FAIL misalign_c1 got=%b exp=110", {bus.busErrorOut, bus.endTransactionOut, bus.dataValidOut});
    end
    tick();
    checks++;
    if ({bus.busErrorOut, bus.endTransactionOut, bus.dataValidOut} !== 3'b000) begin
      failures++; $display("FAIL misalign_c2 got=%b exp=000", {bus.busErrorOut, bus.endTransactionOut, bus.dataValidOut});
    end
    tick();
  endtask

  task automatic test_bounds_write();
    logic [31:0] d;
    logic        ok;
    do_write1(BASE + 32'hFFC, 4'hF, 32'hCAFE_F00D);
    start(BASE + 32'hFFC, 8'd1, 1'b0, 4'hF);
    tick();
    idle_inputs();
    bus.dataValidIn = 1'b1; bus.addressDataIn = 32'hDEAD_BEEF;
    checks++;
    if ({bus.busErrorOut, bus.busyOut} !== 2'b10) begin
      failures++; $display("FAIL bounds_err_c1 got=%b exp=10", {bus.busErrorOut, bus.busyOut});
    end
    tick();
    bus.endTransactionIn = 1'b1;
    checks++;
    if (bus.busErrorOut !== 1'b0) begin failures++; $display("FAIL bounds_err_c2 got=%b exp=0", bus.busErrorOut); end
    tick();
    idle_inputs();
    tick();
    do_read1(BASE + 32'hFFC, d, ok);
    checks++;
    if (!ok || d !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL bounds_mem ok=%b got=%h exp=cafef00d", ok, d);
    end
  endtask

  task automatic test_miss();
    logic [35:0] o;
    start(32'h6000_0000, 8'd0, 1'b1, 4'hF);
    tick();
    idle_inputs();
    o = '0;
    for (int c = 0; c < 8; c++) begin
      o |= {bus.addressDataOut, bus.dataValidOut, bus.endTransactionOut, bus.busyOut, bus.busErrorOut};
      tick();
    end
    checks++;
    if (o !== 36'd0) begin failures++; $display("FAIL miss_quiet got=%h exp=0", o); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d;
    logic        ok;
    start(BASE + 32'h10, 8'd2, 1'b1, 4'hF);
    tick();
    idle_inputs();
    tick();
    tick();
    checks++;
    if (bus.dataValidOut !== 1'b1) begin failures++; $display("FAIL mid_burst_valid got=%b exp=1", bus.dataValidOut); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.dataValidOut, bus.addressDataOut} !== 33'd0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", {bus.dataValidOut, bus.addressDataOut});
    end
    tick();
    reset = 1'b1;
    tick();
    do_read1(BASE + 32'h18, d, ok);
    checks++;
    if (!ok || d !== 32'd30) begin failures++; $display("FAIL post_reset_read ok=%b got=%h exp=1e", ok, d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        ok;
    start(BASE + 32'h30, 8'd0, 1'b0, 4'hF);
    tick();
    idle_inputs();
    bus.addressDataIn = 32'h1234_5678; bus.dataValidIn = 1'b1; bus.endTransactionIn = 1'b1;
    tick();
    idle_inputs();
    do_read1(BASE + 32'h30, d, ok);
    checks++;
    if (!ok || d !== 32'h1234_5678) begin
      failures++; $display("FAIL back_to_back ok=%b got=%h exp=12345678", ok, d);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_write_busy();
    test_read_burst();
    test_byte_enable();
    test_misaligned_read();
    test_bounds_write();
    test_miss();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
